// File: rtl/toycpu_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for the 4-bit toy CPU.
// Define TOYCPU_SEQ_STEP_EN to add the i_step single-instruction start input.
module toycpu_sequencer #(
  parameter int PC_W        = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_run,
`ifdef TOYCPU_SEQ_STEP_EN
  input  logic            i_step,
`endif
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [PC_W-1:0] o_mem_addr,
  output logic [7:0]      o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [7:0]      i_mem_rdata,
  input  logic [3:0]      i_acc,
  input  logic            i_flag_z,
  input  logic            i_flag_c,
  output logic [2:0]      o_alu_op,
  output logic [3:0]      o_alu_b,
  output logic            o_acc_we,
  output logic [2:0]      o_state,
  output logic            o_halted,
  output logic            o_fault
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDM = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

  localparam int WAIT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_t            r_state, w_state_nxt, w_boundary;
  logic [PC_W-1:0]   r_pc, w_pc_nxt, w_opnd_addr;
  logic [7:0]        r_ir, w_ir_nxt;
  logic [3:0]        r_mdr, w_mdr_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [3:0]        w_opcode, w_operand;
  logic              w_start, w_timeout;

  assign w_opcode    = r_ir[7:4];
  assign w_operand   = r_ir[3:0];
  assign w_opnd_addr = PC_W'(w_operand);
  assign w_boundary  = i_run ? ST_FETCH : ST_IDLE;
  // The wait count is the number of unacknowledged cycles already spent in FETCH/MEM.
  assign w_timeout   = (ACK_TIMEOUT > 0) && (r_wait == WAIT_LAST);

`ifdef TOYCPU_SEQ_STEP_EN
  assign w_start = i_run | i_step;
`else
  assign w_start = i_run;
`endif

  // State, program counter, instruction/data latches and ack wait counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= {PC_W{1'b0}};
      r_ir    <= 8'h00;
      r_mdr   <= 4'h0;
      r_wait  <= {WAIT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_mdr   <= w_mdr_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Next-state, PC/IR/MDR update and wait counting.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_mdr_nxt   = r_mdr;
    w_wait_nxt  = {WAIT_W{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_FETCH;
        else         w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (i_mem_ack) begin
          w_ir_nxt    = i_mem_rdata;
          w_pc_nxt    = r_pc + PC_W'(1'b1);
          w_state_nxt = ST_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_wait_nxt  = r_wait + WAIT_W'(1'b1);
        end
      end
      ST_DECODE: begin
        case (w_opcode)
          OP_LD, OP_ST, OP_ADDM: w_state_nxt = ST_MEM;
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_state_nxt = ST_EXEC;
          OP_JMP: begin
            w_pc_nxt    = w_opnd_addr;
            w_state_nxt = w_boundary;
          end
          OP_JZ: begin
            if (i_flag_z) w_pc_nxt = w_opnd_addr;
            else          w_pc_nxt = r_pc;
            w_state_nxt = w_boundary;
          end
          OP_JC: begin
            if (i_flag_c) w_pc_nxt = w_opnd_addr;
            else          w_pc_nxt = r_pc;
            w_state_nxt = w_boundary;
          end
          OP_HLT:  w_state_nxt = ST_HALT;
          default: w_state_nxt = w_boundary;
        endcase
      end
      ST_MEM: begin
        if (i_mem_ack) begin
          if (w_opcode == OP_ST) begin
            w_state_nxt = w_boundary;
          end else begin
            w_mdr_nxt   = i_mem_rdata[3:0];
            w_state_nxt = ST_EXEC;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_wait_nxt  = r_wait + WAIT_W'(1'b1);
        end
      end
      ST_EXEC:  w_state_nxt = w_boundary;
      ST_HALT:  w_state_nxt = ST_HALT;
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode from the registered state, PC, IR and MDR.
  always_comb begin
    o_mem_req  = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_addr = r_pc;
    o_acc_we   = 1'b0;
    o_alu_op   = ALU_PASS;
    o_alu_b    = 4'h0;
    case (r_state)
      ST_FETCH: o_mem_req = 1'b1;
      ST_MEM: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_opnd_addr;
        o_mem_we   = (w_opcode == OP_ST);
      end
      ST_EXEC: begin
        o_acc_we = 1'b1;
        case (w_opcode)
          OP_ADD, OP_ADDM: o_alu_op = ALU_ADD;
          OP_SUB:          o_alu_op = ALU_SUB;
          OP_AND:          o_alu_op = ALU_AND;
          OP_OR:           o_alu_op = ALU_OR;
          OP_XOR:          o_alu_op = ALU_XOR;
          default:         o_alu_op = ALU_PASS;
        endcase
        if ((w_opcode == OP_LD) || (w_opcode == OP_ADDM)) o_alu_b = r_mdr;
        else                                              o_alu_b = w_operand;
      end
      default: o_mem_req = 1'b0;
    endcase
  end

  assign o_mem_wdata = {4'h0, i_acc};
  assign o_state     = r_state;
  assign o_halted    = (r_state == ST_HALT);
  assign o_fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_toycpu_sequencer.sv
// Self-checking bench for toycpu_sequencer: directed scenarios plus random programs
// checked against an instruction-level model of the toy CPU.
module tb_toycpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, mem_req, mem_we, mem_ack, flag_z, flag_c, acc_we, halted, fault;
  logic [3:0] mem_addr, acc, alu_b;
  logic [7:0] mem_wdata, mem_rdata;
  logic [2:0] alu_op, state;
`ifdef TOYCPU_SEQ_STEP_EN
  logic       step;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic       we;
    logic [7:0] wdata;
  } tx_t;

  logic [7:0] mem      [16];
  logic [7:0] mem_init [16];
  tx_t        exp_tx[$];
  logic [6:0] exp_alu[$];
  int         exp_cyc;
  bit         exp_halt;
  logic [3:0] exp_pc;

  toycpu_sequencer #(.PC_W(4), .ACK_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run),
`ifdef TOYCPU_SEQ_STEP_EN
    .i_step(step),
`endif
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .i_acc(acc),
    .i_flag_z(flag_z), .i_flag_c(flag_c), .o_alu_op(alu_op), .o_alu_b(alu_b),
    .o_acc_we(acc_we), .o_state(state), .o_halted(halted), .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datapath behaviour assumed by the bench: returns {z, c, result}.
  function automatic logic [5:0] alu_eval(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    case (op)
      3'd0:    s = {1'b0, b};
      3'd1:    s = {1'b0, a} + {1'b0, b};
      3'd2:    s = {(a < b), 4'(a - b)};
      3'd3:    s = {1'b0, a & b};
      3'd4:    s = {1'b0, a | b};
      3'd5:    s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    return {(s[3:0] == 4'h0), s[4], s[3:0]};
  endfunction

  // Instruction-level model: expected bus transactions, ALU strobes, cycle count, final PC.
  task automatic model_run(input int limit);
    logic [7:0] m [16];
    logic [7:0] ir;
    logic [3:0] pc, a, k, b;
    logic [2:0] op;
    logic       z, c, do_alu;
    logic [5:0] res;
    m = mem_init;
    pc = 4'h0; a = 4'h0; z = 1'b0; c = 1'b0;
    exp_tx.delete(); exp_alu.delete();
    exp_cyc = 1; exp_halt = 1'b0;
    for (int n = 0; n < limit && !exp_halt; n++) begin
      ir = m[pc];
      exp_tx.push_back(tx_t'({pc, 1'b0, 4'h0, a}));
      pc = pc + 4'd1;
      k = ir[3:0]; b = k; op = 3'd0; do_alu = 1'b0;
      case (ir[7:4])
        4'h1, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9: begin
          do_alu = 1'b1; exp_cyc += 3;
          if (ir[7:4] == 4'h1)      op = 3'd0;
          else if (ir[7:4] == 4'h4) op = 3'd1;
          else                      op = 3'(ir[7:4] - 4'd4);
        end
        4'h2, 4'h5: begin
          exp_tx.push_back(tx_t'({k, 1'b0, 4'h0, a}));
          b = m[k][3:0]; do_alu = 1'b1; exp_cyc += 4;
          op = (ir[7:4] == 4'h2) ? 3'd0 : 3'd1;
        end
        4'h3: begin
          exp_tx.push_back(tx_t'({k, 1'b1, 4'h0, a}));
          m[k] = {4'h0, a}; exp_cyc += 3;
        end
        4'hA: begin pc = k; exp_cyc += 2; end
        4'hB: begin if (z) pc = k; exp_cyc += 2; end
        4'hC: begin if (c) pc = k; exp_cyc += 2; end
        4'hF: begin exp_halt = 1'b1; exp_cyc += 2; end
        default: exp_cyc += 2;
      endcase
      if (do_alu) begin
        exp_alu.push_back({op, b});
        res = alu_eval(op, a, b);
        a = res[3:0]; c = res[4]; z = res[5];
      end
    end
    exp_pc = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    acc = 4'h0; flag_z = 1'b0; flag_c = 1'b0; we_cnt = 0;
`ifdef TOYCPU_SEQ_STEP_EN
    step = 1'b0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic fill_init(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem_init[i] = v;
  endtask

  // Zero-wait memory responder for hand-stepped scenarios.
  task automatic tick_auto();
    mem_ack = mem_req; mem_rdata = mem[mem_addr];
    if (acc_we) we_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic run_prog(input string tag, input int limit, input int wmax);
    int cyc, waits, wcnt;
    tx_t obs_tx, hold_tx;
    logic [5:0] res;
    logic upd;
    model_run(limit);
    mem = mem_init;
    do_reset();
    run = 1'b1; cyc = 0; waits = 0; wcnt = -1; res = 6'h00; hold_tx = '0;
    while (cyc < 3000) begin
      if (halted || fault) break;
      if (!exp_halt && exp_tx.size() == 0 && exp_alu.size() == 0) break;
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
      if (mem_req) begin
        obs_tx = {mem_addr, mem_we, mem_wdata};
        if (wcnt < 0) begin
          wcnt = int'($urandom_range(wmax, 0));
          hold_tx = obs_tx;
        end else begin
          chk({tag, " hold"}, 32'(obs_tx), 32'(hold_tx));
        end
        if (wcnt == 0) begin
          mem_ack = 1'b1; mem_rdata = mem[mem_addr];
          if (exp_tx.size() == 0) chk({tag, " tx count"}, 32'(exp_tx.size()), 32'd1);
          else chk({tag, " tx"}, 32'(obs_tx), 32'(exp_tx.pop_front()));
          if (mem_we) mem[mem_addr] = mem_wdata;
          wcnt = -1;
        end else begin
          wcnt--; waits++;
        end
      end
      upd = acc_we;
      if (acc_we) begin
        if (exp_alu.size() == 0) chk({tag, " alu count"}, 32'(exp_alu.size()), 32'd1);
        else chk({tag, " alu"}, 32'({alu_op, alu_b}), 32'(exp_alu.pop_front()));
        res = alu_eval(alu_op, acc, alu_b);
      end
      @(posedge clk); #1;
      if (upd) begin acc = res[3:0]; flag_c = res[4]; flag_z = res[5]; end
      cyc++;
    end
    chk({tag, " halted"}, 32'(halted), 32'(exp_halt));
    chk({tag, " fault"}, 32'(fault), 32'd0);
    chk({tag, " drained"}, 32'(exp_tx.size() + exp_alu.size()), 32'd0);
    if (exp_halt) begin
      chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc + waits));
      chk({tag, " pc"}, 32'(mem_addr), 32'(exp_pc));
    end
    run = 1'b0;
  endtask

  initial begin
    fill_init(8'h00);
    mem = mem_init;
    do_reset();
    chk("reset outputs", 32'({mem_req, mem_we, acc_we, halted, fault, alu_op, alu_b, mem_addr}), 32'd0);
    chk("reset state", 32'(state), 32'd0);

    fill_init(8'h00); mem_init[0] = 8'h13; mem_init[1] = 8'h42; mem_init[2] = 8'hF0;
    run_prog("ldi_add_hlt", 10, 0);

    fill_init(8'h00); mem_init[0] = 8'h17; mem_init[1] = 8'h35; mem_init[2] = 8'hF0;
    run_prog("store", 10, 0);

    fill_init(8'h00); mem_init[0] = 8'h10; mem_init[1] = 8'hB9; mem_init[2] = 8'hF0; mem_init[9] = 8'hF0;
    run_prog("jz_taken", 10, 0);
    mem_init[0] = 8'h11;
    run_prog("jz_not_taken", 10, 0);

    fill_init(8'h00); mem_init[0] = 8'h19; mem_init[1] = 8'h4A; mem_init[2] = 8'hC5; mem_init[5] = 8'hF0;
    run_prog("jc_taken", 10, 1);

    fill_init(8'h00);
    run_prog("pc_wrap", 17, 0);

    fill_init(8'h00); mem_init[0] = 8'h2E; mem_init[1] = 8'h5F; mem_init[2] = 8'hF0;
    mem_init[14] = 8'h06; mem_init[15] = 8'h0B;
    run_prog("ld_addm_waits", 10, 2);

    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) mem_init[i] = 8'($urandom);
      run_prog($sformatf("rand%0d", p), 24, 2);
    end

    // Ack never arrives: fault after the full wait budget.
    mem = mem_init;
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 15) begin
        chk("timeout req held", 32'(mem_req), 32'd1);
        chk("timeout early fault", 32'(fault), 32'd0);
      end
    end
    chk("timeout fault", 32'(fault), 32'd1);
    chk("timeout req drop", 32'(mem_req), 32'd0);
    chk("timeout state", 32'(state), 32'd6);
    @(posedge clk); #1;
    chk("fault sticky", 32'(fault), 32'd1);

    // Asynchronous reset in the middle of a pending fetch.
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    chk("midwait req", 32'(mem_req), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async reset outputs",
        32'({mem_req, mem_we, acc_we, halted, fault, alu_op, alu_b, mem_addr, state}), 32'd0);

    // run dropped mid-instruction: the instruction finishes, then IDLE.
    fill_init(8'h00); mem_init[0] = 8'h11; mem_init[1] = 8'h12;
    mem = mem_init;
    do_reset();
    run = 1'b1;
    tick_auto();
    run = 1'b0;
    for (int k = 0; k < 3; k++) tick_auto();
    chk("runlow state", 32'(state), 32'd0);
    chk("runlow pc", 32'(mem_addr), 32'd1);
    chk("runlow acc_we", 32'(we_cnt), 32'd1);
    for (int k = 0; k < 3; k++) tick_auto();
    chk("runlow stays idle", 32'(state), 32'd0);

`ifdef TOYCPU_SEQ_STEP_EN
    do_reset();
    step = 1'b1;
    tick_auto();
    step = 1'b0;
    for (int k = 0; k < 6; k++) tick_auto();
    chk("step state", 32'(state), 32'd0);
    chk("step pc", 32'(mem_addr), 32'd1);
    chk("step acc_we", 32'(we_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/toycpu_sequencer.md
# toycpu_sequencer

Multi-cycle control unit for the 4-bit toy CPU core. It owns the program counter (PC) and instruction register (IR) and fetches 8-bit instructions over a req/ack memory port. It decodes each instruction and drives the external ALU/accumulator datapath with one-hot-in-time strobes. It sits between the shared program/data memory and the accumulator datapath, inside the top-level TinyTapeout wrapper.

## Interface
- PC_W, 4: PC and memory address width, legal 4..8.
- ACK_TIMEOUT, 15: max wait cycles for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  level; allows execution to proceed at instruction boundaries.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, valid while mem_req is high.
- mem_addr  out  PC_W  access address.
- mem_wdata  out  8  {4'b0, acc}.
- mem_ack  in  1  access complete; rdata is valid in the same cycle.
- mem_rdata  in  8  read data.
- acc  in  4  current accumulator value.
- flag_z, flag_c  in  1 each  datapath flags, registered by the datapath.
- alu_op  out  3  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
- alu_b  out  4  ALU B operand.
- acc_we  out  1  accumulator/flags write strobe.
- state  out  3  debug view of the FSM state.
- halted, fault  out  1 each  status.

## Operation
Instruction format: opcode = ir[7:4], operand = ir[3:0].

Opcodes:
- 0 NOP
- 1 LDI (acc = imm)
- 2 LD (acc = mem)
- 3 ST
- 4 ADD imm
- 5 ADDM
- 6 SUB imm
- 7 AND imm
- 8 OR imm
- 9 XOR imm
- A JMP
- B JZ
- C JC
- D, E treated as NOP
- F HLT

Memory operand address and jump target are the operand zero-extended to PC_W.

FSM states (state encoding): IDLE 0, FETCH 1, DECODE 2, MEM 3, EXEC 4, HALT 5, FAULT 6.

- IDLE: run=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: ir<=mem_rdata, pc<=pc+1 (wraps modulo 2^PC_W), go to DECODE.
- DECODE (1 cycle):
  - LD/ST/ADDM -> MEM.
  - LDI/ADD/SUB/AND/OR/XOR -> EXEC.
  - JMP, or JZ with flag_z=1, or JC with flag_c=1: pc<=operand, go to boundary. Untaken jumps go to boundary.
  - NOP -> boundary.
  - HLT -> HALT.
- MEM: mem_req=1, mem_addr=operand, mem_we=1 only for ST. On mem_ack: ST -> boundary; LD/ADDM latch mdr<=mem_rdata[3:0], then go to EXEC.
- EXEC (1 cycle): acc_we=1. alu_op = PASS for LDI/LD, ADD for ADD/ADDM, otherwise per opcode. alu_b = mdr for LD/ADDM, else operand. Then go to boundary.
- Boundary: FETCH if run=1 in that cycle, else IDLE.
- Timeout: a wait counter runs in FETCH/MEM, cleared on state entry. If ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT without mem_ack -> FAULT.
- HALT (halted=1) and FAULT (fault=1) are exited only by rst.
- Outputs are Moore-decoded from registered state/pc/ir/mdr. In all states other than FETCH/MEM: mem_req=0 and mem_addr=pc.

## Timing
- Reset values: state=IDLE, pc=0, ir=0, mdr=0. All outputs are 0: mem_req, mem_we, acc_we, alu_op, alu_b, halted, fault. mem_addr=0.
- Reset mid-access drops mem_req asynchronously and abandons the access.
- Cycles per instruction with zero-wait ack (ack in the first req cycle):
  - JMP/NOP/Jcc: 2
  - LDI/ALU-imm: 3
  - ST: 3
  - LD/ADDM: 4
- Each wait cycle on mem_ack adds 1.
- mem_req stays high and mem_addr/mem_we/mem_wdata stay stable until the ack cycle. mem_req is deasserted in the cycle after ack.
- acc_we is high for exactly 1 cycle per ALU instruction. Flags sampled in DECODE reflect all prior EXEC writes.
- run falling mid-instruction has no effect until the boundary.

## Configuration
TOYCPU_SEQ_STEP_EN:
- Defined: adds input port step (1 bit). In IDLE, step=1 (with run=0) starts exactly one instruction. The boundary after it returns to IDLE unless run=1. step is ignored in all other states.
- Undefined: the port is absent and only run starts execution.

## Test plan
- Reset then run=1, memory {0:0x13, 1:0x42, 2:0xF0}, zero-wait ack -> acc_we pulses with alu_op=PASS, alu_b=3, then with ADD, alu_b=2. halted=1 at cycle 9 after run; pc=3.
- ST: acc=0x7, program {0:0x35} -> a single MEM cycle with mem_we=1, mem_addr=5, mem_wdata=0x07.
- JZ: flag_z=1, program {0:0xB9} -> next fetch mem_addr=9. With flag_z=0 -> next fetch mem_addr=1.
- PC wrap: memory all 0x00, PC_W=4 -> fetch address sequence 14, 15, 0.
- mem_ack held low, ACK_TIMEOUT=15 -> fault=1 after 15 wait cycles, mem_req=0. Asserting rst mid-wait -> all outputs 0 immediately.
- With TOYCPU_SEQ_STEP_EN: one step pulse on program {0:0x11, 1:0x12} -> exactly one acc_we pulse, then state=IDLE, pc=1.
